// File: rtl/dmem_responder.sv
// Data-memory responder for the multi-cycle 16-bit processor: a word-addressed RAM
// that answers one load/store at a time after WAIT_CYCLES wait states.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         DATA_W    = 16;
    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        cnt;
    logic              cap_wr;
    logic [15:0]       cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              do_access;
    logic              acc_wr;
    logic              acc_oor;
    logic [15:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0)
                        state_nxt = RESP;
                    else
                        state_nxt = WAIT;
                end
            end
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // With zero wait states the access happens on the accept edge, so it must
    // use the live request rather than the not-yet-captured copy.
    assign accept    = req_ready && req_valid;
    assign do_access = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));
    assign acc_wr    = (state == IDLE) ? req_wr    : cap_wr;
    assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    assign acc_oor   = |acc_addr[15:ADDR_W];

    always_ff @(posedge clk) begin
        if (!resetn)
            cnt <= 4'd0;
        else if (accept && (WAIT_CYCLES != 0))
            cnt <= WAIT_INIT;
        else if (state == WAIT)
            cnt <= cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_wr    <= req_wr;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    // Reset on the access edge cancels the write as well as the response.
    always_ff @(posedge clk) begin
        if (resetn && do_access && acc_wr && !acc_oor)
            mem[acc_addr[ADDR_W-1:0]] <= acc_wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (do_access) begin
            rsp_err   <= acc_oor;
            rsp_rdata <= (acc_wr || acc_oor) ? '0 : mem[acc_addr[ADDR_W-1:0]];
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the multi-cycle 16-bit processor. It services the load and store requests that the controller and datapath issue during the memory-access phase, playing the memory end of that interface. It holds a word-addressed RAM and applies a configurable number of wait states. It returns read data and an error flag with a one-cycle response pulse. It sits between the datapath's address/DMem_in registers and its DMem_out register.

## Interface
- ADDR_W, 8: implemented address bits; RAM depth is 2^ADDR_W 16-bit words.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and response, legal range 0..15.
- clk  input  1  clock; all state changes on the rising edge.
- resetn  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present; sampled only while req_ready=1.
- req_wr  input  1  1 = store (SW/SM), 0 = load (LW/LM).
- req_addr  input  16  word address (ALU output).
- req_wdata  input  16  store data (DMem_in register).
- req_ready  output  1  responder idle and able to accept a request.
- rsp_valid  output  1  one-cycle pulse marking completion of the accepted request.
- rsp_rdata  output  16  load data; valid while rsp_valid=1.
- rsp_err  output  1  request address was out of range; valid while rsp_valid=1.
- busy  output  1  request in flight; equals ~req_ready.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture req_wr, req_addr and req_wdata into internal registers. The request is then accepted.
  - If WAIT_CYCLES=0, go to RESP and perform the access on the same edge. Otherwise load wait counter = WAIT_CYCLES and go to WAIT.
- WAIT:
  - req_ready=0. Counter decrements each cycle.
  - On the edge where counter==1, perform the access and go to RESP.
  - req_* inputs are ignored; only the captured copy is used.
- Access:
  - An address is out of range when captured addr[15:ADDR_W] != 0.
  - In range, store: RAM[addr[ADDR_W-1:0]] <= wdata. Response carries rsp_rdata=0, rsp_err=0.
  - In range, load: rsp_rdata <= RAM[addr]. Response carries rsp_err=0.
  - Out of range: no RAM write. Response carries rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1 for exactly this cycle. req_ready=0.
  - Unconditionally go to IDLE. There is no response backpressure; the processor consumes the response in its memory-access cycle.
- rsp_rdata and rsp_err hold their last values until the next access. Verification may only check them while rsp_valid=1.
- RAM contents are not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: req_ready=1 from the first cycle after reset; busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; wait counter 0.
- Latency: the accept edge is E0. rsp_valid is high in cycle E0+WAIT_CYCLES+1, i.e. WAIT_CYCLES+1 cycles after E0, for exactly one cycle.
- For a store, the RAM write commits on the edge that enters RESP.
- A load issued immediately after a store to the same address returns the new data.
- Throughput: one request per WAIT_CYCLES+2 cycles. req_ready returns to 1 in the cycle after RESP.
- req_valid held high across a completed request: it is accepted again as a new request once IDLE is reached. The requester must drop req_valid on seeing rsp_valid.
- Reset asserted in WAIT: return to IDLE and clear the counter, with no RAM write and no rsp_valid.
- Reset asserted in RESP: rsp_valid drops next cycle. The already-committed write stands.
- Reset takes priority over every transition on the same edge.
- WAIT_CYCLES=15: the counter must not wrap. Use a 4-bit counter with exact decrement to 1.

## Test plan
- Reset with WAIT_CYCLES=2 -> cycle after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Store then load, WAIT_CYCLES=2:
  - Store addr 0x0005, data 0xBEEF accepted at E0 -> rsp_valid exactly at E0+3, rsp_err=0, req_ready=0 for 3 cycles.
  - Then load addr 0x0005 -> rsp_rdata=0xBEEF.
- Out-of-range store, ADDR_W=8: store addr 0x0105, data 0x1234 -> rsp_err=1. A following load from 0x0005 still returns 0xBEEF (no aliasing write).
- WAIT_CYCLES=0: back-to-back held req_valid with stores to 0x0010 (0x0001) and 0x0011 (0x0002) -> rsp_valid one cycle after each accept, with accepts two cycles apart. Loads return 0x0001 and 0x0002.
- Reset mid-operation: store addr 0x0020, data 0xAAAA; assert resetn=0 in the second WAIT cycle -> no rsp_valid, and a later load of 0x0020 does not return 0xAAAA. Pre-load 0x0020 with 0x5555 first and expect 0x5555.
- WAIT_CYCLES=15: load addr 0x00FF after storing 0x7F7F -> rsp_valid exactly 16 cycles after accept, rsp_rdata=0x7F7F, busy high for 16 cycles.
